// File: rtl/serial_adder.sv
// Bit-serial adder: latches operands on start, emits one sum bit per clock LSB first.
// Define SERIAL_ADDER_SUB_EN to add the sub port for two's-complement subtraction.
module serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] S,
  output logic         Co
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          c_q, c_d;
  logic          co_q, co_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [W-1:0]  bLoad;
  logic          cLoad;
  logic          sumBit;
  logic          carryNext;

  // Subtraction is A + ~B + ~Ci, so only the loaded B and carry change.
`ifdef SERIAL_ADDER_SUB_EN
  assign bLoad = sub ? ~B : B;
  assign cLoad = sub ? ~Ci : Ci;
`else
  assign bLoad = B;
  assign cLoad = Ci;
`endif

  assign sumBit    = a_q[0] ^ b_q[0] ^ c_q;
  assign carryNext = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      co_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      c_q     <= c_d;
      co_q    <= co_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    c_d     = c_q;
    co_d    = co_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = bLoad;
          c_d     = cLoad;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Shift form keeps W=1 legal: the sum bit lands directly in bit 0.
        s_d   = (s_q >> 1) | (W'(sumBit) << (W - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = carryNext;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          co_d    = carryNext;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign S    = s_q;
  assign Co   = co_q;

endmodule
